// File: rtl/cronometro_decimal.sv
// Decimal stopwatch counting 0..9999 in TICK_HZ steps, with debounced start/stop and clear buttons.
// Optional lap-freeze button enabled by defining CRONOMETRO_VOLTA_EN.
module cronometro_decimal #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 10,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_iniciar_parar,
  input  logic        btn_zerar,
`ifdef CRONOMETRO_VOLTA_EN
  input  logic        btn_volta,
`endif
  output logic [15:0] dado_binario_saida,
  output logic        rodando,
  output logic        estouro
);

  localparam int PRESC_DIV = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
  localparam int PW        = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);

  localparam int DEB = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES : 1;
  localparam int DW  = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB - 1);

  localparam logic [15:0] CONTA_MAX = 16'd9999;

`ifdef CRONOMETRO_VOLTA_EN
  localparam int N_BTN = 3;
`else
  localparam int N_BTN = 2;
`endif

  typedef enum logic [1:0] {
    PARADO,
    RODANDO,
    PAUSADO,
    SATURADO
  } estado_t;

  // Button bit order: 0 = iniciar/parar, 1 = zerar, 2 = volta.
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] nivel_q;
  logic [N_BTN-1:0] pulso_q;
  logic [DW-1:0]    deb_cnt_q [N_BTN];

`ifdef CRONOMETRO_VOLTA_EN
  assign btn_raw = {btn_volta, btn_zerar, btn_iniciar_parar};
`else
  assign btn_raw = {btn_zerar, btn_iniciar_parar};
`endif

  logic pulso_iniciar;
  logic pulso_zerar;
  assign pulso_iniciar = pulso_q[0];
  assign pulso_zerar   = pulso_q[1];

  // A level is accepted after DEB consecutive samples that differ from the
  // current accepted level; the pulse marks only the accepted 0->1 change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      nivel_q <= '0;
      pulso_q <= '0;
      // NOTE: the counter array is tiny and must restart from zero after reset, so it is reset like any other register rather than treated as RAM.
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments here keep the two synchronizer stages as separate flops; blocking would collapse them into one.
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < N_BTN; i++) begin
        pulso_q[i] <= 1'b0;
        if (sync2_q[i] == nivel_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_MAX) begin
          nivel_q[i]   <= sync2_q[i];
          deb_cnt_q[i] <= '0;
          pulso_q[i]   <= sync2_q[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  estado_t       state_q, state_d;
  logic [15:0]   conta_q, conta_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [15:0]   dado_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can leave a value unassigned and infer a latch.
    state_d = state_q;
    conta_d = conta_q;
    presc_d = presc_q;
    tick    = (state_q == RODANDO) && (presc_q == PRESC_MAX);

    // Outside RODANDO the prescaler simply holds, so a pause keeps the fraction.
    if (state_q == RODANDO) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    case (state_q)
      PARADO: begin
        if (pulso_iniciar) state_d = RODANDO;
      end
      RODANDO: begin
        if (tick) begin
          if (conta_q >= CONTA_MAX - 16'd1) begin
            conta_d = CONTA_MAX;
            state_d = SATURADO;
          end else begin
            conta_d = conta_q + 16'd1;
          end
        end
        if (pulso_iniciar && (state_d != SATURADO)) state_d = PAUSADO;
      end
      PAUSADO: begin
        if (pulso_iniciar) state_d = RODANDO;
      end
      SATURADO: begin
        state_d = SATURADO;
      end
      default: begin
        state_d = PARADO;
        conta_d = '0;
        presc_d = '0;
      end
    endcase

    // Clear has priority over everything, including a simultaneous start.
    if (pulso_zerar) begin
      state_d = PARADO;
      conta_d = '0;
      presc_d = '0;
    end
  end

`ifdef CRONOMETRO_VOLTA_EN
  logic        pulso_volta;
  logic        travado_q, travado_d;
  logic [15:0] volta_q, volta_d;

  assign pulso_volta = pulso_q[2];

  always_comb begin
    travado_d = travado_q;
    volta_d   = volta_q;
    if (pulso_volta && (state_q == RODANDO)) begin
      travado_d = !travado_q;
      volta_d   = conta_q;
    end
    // Any exit from RODANDO (pause, saturation, clear) releases the freeze.
    if (state_d != RODANDO) travado_d = 1'b0;
    dado_d = travado_d ? volta_d : conta_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      travado_q <= 1'b0;
      volta_q   <= '0;
    end else begin
      travado_q <= travado_d;
      volta_q   <= volta_d;
    end
  end
`else
  assign dado_d = conta_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= PARADO;
      conta_q            <= '0;
      presc_q            <= '0;
      dado_binario_saida <= '0;
      rodando            <= 1'b0;
      estouro            <= 1'b0;
    end else begin
      state_q            <= state_d;
      conta_q            <= conta_d;
      presc_q            <= presc_d;
      dado_binario_saida <= dado_d;
      rodando            <= (state_d == RODANDO);
      estouro            <= (state_d == SATURADO);
    end
  end

endmodule

// File: tb/tb_cronometro_decimal.sv
// Bench for cronometro_decimal: a 10-clk-per-count instance for the main table and a
// 1-clk-per-count instance to reach saturation quickly. Lap checks need CRONOMETRO_VOLTA_EN.
module tb_cronometro_decimal;

  logic clk;
  logic reset_n;
  logic btn_ini, btn_zer;
  logic f_ini, f_zer;
  logic [15:0] dado_l, dado_r;
  logic rod_l, rod_r, est_l, est_r;
`ifdef CRONOMETRO_VOLTA_EN
  logic btn_vol;
`endif

  int n_checks = 0;
  int n_err    = 0;

  cronometro_decimal #(
    .CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYCLES(4)
  ) u_lento (
    .clk                (clk),
    .reset_n            (reset_n),
    .btn_iniciar_parar  (btn_ini),
    .btn_zerar          (btn_zer),
`ifdef CRONOMETRO_VOLTA_EN
    .btn_volta          (btn_vol),
`endif
    .dado_binario_saida (dado_l),
    .rodando            (rod_l),
    .estouro            (est_l)
  );

  cronometro_decimal #(
    .CLK_HZ(10), .TICK_HZ(10), .DEBOUNCE_CYCLES(4)
  ) u_rapido (
    .clk                (clk),
    .reset_n            (reset_n),
    .btn_iniciar_parar  (f_ini),
    .btn_zerar          (f_zer),
`ifdef CRONOMETRO_VOLTA_EN
    .btn_volta          (1'b0),
`endif
    .dado_binario_saida (dado_r),
    .rodando            (rod_r),
    .estouro            (est_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string nome;
    bit    rapido;
    int    dado;
    int    tol;
    logic  rod;
    logic  est;
  } esperado_t;

  esperado_t sb_q[$];

  typedef struct {
    string nome;
    logic  ini;
    logic  zer;
    int    ciclos;
    int    dado;
    logic  rod;
    logic  est;
  } vetor_t;

  vetor_t tab[16];

  task automatic check(input string nome, input int atual, input int esperado, input int tol);
    n_checks++;
    if (atual < esperado - tol || atual > esperado + tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", nome, atual, esperado, tol);
    end
  endtask

  // Drives buttons at a falling edge, queues the expectation, advances, then compares.
  task automatic aplicar(input string nome, input bit rapido, input logic a_ini, input logic a_zer,
                         input int ciclos, input bit chk, input int e_dado, input int tol,
                         input logic e_rod, input logic e_est);
    esperado_t e;
    if (rapido) begin
      f_ini = a_ini;
      f_zer = a_zer;
    end else begin
      btn_ini = a_ini;
      btn_zer = a_zer;
    end
    if (chk) sb_q.push_back('{nome, rapido, e_dado, tol, e_rod, e_est});
    repeat (ciclos) @(negedge clk);
    if (chk) begin
      e = sb_q.pop_front();
      check({e.nome, ".dado"}, int'(e.rapido ? dado_r : dado_l), e.dado, e.tol);
      check({e.nome, ".rodando"}, int'(e.rapido ? rod_r : rod_l), int'(e.rod), 0);
      check({e.nome, ".estouro"}, int'(e.rapido ? est_r : est_l), int'(e.est), 0);
    end
  endtask

  initial begin
    // Start is effective 7 edges after a press; ticks then every 10 edges.
    tab[0]  = '{"inicio",      1'b1, 1'b0, 10, 0, 1'b1, 1'b0};
    tab[1]  = '{"conta5",      1'b0, 1'b0, 50, 5, 1'b1, 1'b0};
    tab[2]  = '{"zerar",       1'b0, 1'b1, 10, 0, 1'b0, 1'b0};
    tab[3]  = '{"parado",      1'b0, 1'b0, 10, 0, 1'b0, 1'b0};
    tab[4]  = '{"reinicio",    1'b1, 1'b0, 10, 0, 1'b1, 1'b0};
    tab[5]  = '{"conta2",      1'b0, 1'b0, 25, 2, 1'b1, 1'b0};
    tab[6]  = '{"pausa",       1'b1, 1'b0, 10, 3, 1'b0, 1'b0};
    tab[7]  = '{"pausa_meio",  1'b0, 1'b0, 50, 3, 1'b0, 1'b0};
    tab[8]  = '{"pausa_fim",   1'b0, 1'b0, 50, 3, 1'b0, 1'b0};
    tab[9]  = '{"retoma",      1'b1, 1'b0, 10, 3, 1'b1, 1'b0};
    tab[10] = '{"fracao",      1'b0, 1'b0,  3, 4, 1'b1, 1'b0};
    tab[11] = '{"conta6",      1'b0, 1'b0, 20, 6, 1'b1, 1'b0};
    tab[12] = '{"pausa2",      1'b1, 1'b0, 10, 6, 1'b0, 1'b0};
    tab[13] = '{"pausa2_fim",  1'b0, 1'b0, 10, 6, 1'b0, 1'b0};
    tab[14] = '{"simultaneo",  1'b1, 1'b1, 10, 0, 1'b0, 1'b0};
    tab[15] = '{"parado2",     1'b0, 1'b0, 10, 0, 1'b0, 1'b0};

    reset_n = 1'b1;
    btn_ini = 1'b0;
    btn_zer = 1'b0;
    f_ini   = 1'b0;
    f_zer   = 1'b0;
`ifdef CRONOMETRO_VOLTA_EN
    btn_vol = 1'b0;
`endif
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.dado_l",   int'(dado_l), 0, 0);
    check("reset.rodando_l", int'(rod_l), 0, 0);
    check("reset.estouro_l", int'(est_l), 0, 0);
    check("reset.dado_r",   int'(dado_r), 0, 0);
    check("reset.estouro_r", int'(est_r), 0, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      aplicar(tab[i].nome, 1'b0, tab[i].ini, tab[i].zer, tab[i].ciclos, 1'b1,
              tab[i].dado, 0, tab[i].rod, tab[i].est);
    end

    // Reset mid-run discards progress; a button held through reset pulses once.
    aplicar("pre_reset_a", 1'b0, 1'b1, 1'b0, 10, 1'b0, 0, 0, 1'b0, 1'b0);
    aplicar("pre_reset",   1'b0, 1'b0, 1'b0, 30, 1'b1, 3, 0, 1'b1, 1'b0);
    btn_ini = 1'b1;
    reset_n = 1'b0;
    #1;
    check("reset_async.dado",    int'(dado_l), 0, 0);
    check("reset_async.rodando", int'(rod_l), 0, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    aplicar("pos_reset",   1'b0, 1'b1, 1'b0, 10, 1'b1, 0, 0, 1'b1, 1'b0);
    aplicar("pos_reset_b", 1'b0, 1'b0, 1'b0, 20, 1'b1, 2, 0, 1'b1, 1'b0);
    aplicar("limpa_a",     1'b0, 1'b0, 1'b1, 10, 1'b0, 0, 0, 1'b0, 1'b0);
    aplicar("limpa_b",     1'b0, 1'b0, 1'b0, 10, 1'b1, 0, 0, 1'b0, 1'b0);

    // Bounce 1-0-1 then hold: one start only, effective 11 edges after bounce begins.
    aplicar("ressalto_a",  1'b0, 1'b1, 1'b0,  2, 1'b0, 0, 0, 1'b0, 1'b0);
    aplicar("ressalto_b",  1'b0, 1'b0, 1'b0,  2, 1'b0, 0, 0, 1'b0, 1'b0);
    aplicar("ressalto_c",  1'b0, 1'b1, 1'b0, 40, 1'b1, 3, 0, 1'b1, 1'b0);
    aplicar("ressalto_d",  1'b0, 1'b0, 1'b0, 10, 1'b1, 4, 0, 1'b1, 1'b0);
    aplicar("limpa_c",     1'b0, 1'b0, 1'b1, 10, 1'b0, 0, 0, 1'b0, 1'b0);
    aplicar("limpa_d",     1'b0, 1'b0, 1'b0, 10, 1'b1, 0, 0, 1'b0, 1'b0);

`ifdef CRONOMETRO_VOLTA_EN
    // Freeze takes effect at edge 79 with count 7; release at edge 117 shows live 11.
    aplicar("volta_ini",   1'b0, 1'b1, 1'b0, 10, 1'b0, 0, 0, 1'b0, 1'b0);
    aplicar("volta_run",   1'b0, 1'b0, 1'b0, 62, 1'b1, 6, 0, 1'b1, 1'b0);
    btn_vol = 1'b1;
    aplicar("volta_trava", 1'b0, 1'b0, 1'b0, 10, 1'b0, 0, 0, 1'b0, 1'b0);
    btn_vol = 1'b0;
    aplicar("volta_7",     1'b0, 1'b0, 1'b0, 18, 1'b1, 7, 0, 1'b1, 1'b0);
    aplicar("volta_30",    1'b0, 1'b0, 1'b0, 10, 1'b1, 7, 0, 1'b1, 1'b0);
    btn_vol = 1'b1;
    aplicar("volta_livre", 1'b0, 1'b0, 1'b0, 10, 1'b1, 11, 0, 1'b1, 1'b0);
    btn_vol = 1'b0;
    aplicar("volta_zer_a", 1'b0, 1'b0, 1'b1, 10, 1'b0, 0, 0, 1'b0, 1'b0);
    aplicar("volta_zer_b", 1'b0, 1'b0, 1'b0, 10, 1'b1, 0, 0, 1'b0, 1'b0);
`endif

    // Fast instance: one count per clk once running, count n at edge 7+n.
    aplicar("sat_ini",     1'b1, 1'b1, 1'b0,   10, 1'b0, 0,    0, 1'b0, 1'b0);
    aplicar("sat_9998",    1'b1, 1'b0, 1'b0, 9995, 1'b1, 9998, 0, 1'b1, 1'b0);
    aplicar("sat_9999",    1'b1, 1'b0, 1'b0,    1, 1'b1, 9999, 0, 1'b0, 1'b1);
    aplicar("sat_ignora",  1'b1, 1'b1, 1'b0,   10, 1'b1, 9999, 0, 1'b0, 1'b1);
    aplicar("sat_mantem",  1'b1, 1'b0, 1'b0,  190, 1'b1, 9999, 0, 1'b0, 1'b1);
    aplicar("sat_zerar",   1'b1, 1'b0, 1'b1,   10, 1'b1, 0,    0, 1'b0, 1'b0);
    aplicar("sat_parado",  1'b1, 1'b0, 1'b0,   10, 1'b1, 0,    0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cronometro_decimal.md
CRONOMETRO_DECIMAL -- requirements
Module: cronometro_decimal

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 10, count rate in Hz (one count = 0.1 s).
REQ-003 Parameter DEBOUNCE_CYCLES, default 1_000_000, number of stable cycles required to accept a button level.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 btn_iniciar_parar  input  1  raw start/stop button, active high, asynchronous to clk.
REQ-007 btn_zerar  input  1  raw clear button, active high, asynchronous to clk.
REQ-008 btn_volta  input  1  raw lap button, active high; present only when CRONOMETRO_VOLTA_EN is defined.
REQ-009 dado_binario_saida  output  16  displayed count, binary, range 0..9999; feeds the display controller's 16-bit binary input.
REQ-010 rodando  output  1  high while in state RODANDO.
REQ-011 estouro  output  1  high while in state SATURADO.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-013 A debounced 0->1 transition SHALL produce exactly one 1-cycle internal pulse; holding the button SHALL NOT repeat it.
REQ-014 Prescaler SHALL count 0..(CLK_HZ/TICK_HZ)-1 only in RODANDO, emitting a 1-cycle tick on the terminal value and wrapping to 0.
REQ-015 Leaving RODANDO SHALL freeze the prescaler (pause keeps the fractional interval); zerar SHALL clear it to 0.
REQ-016 States: PARADO (count 0), RODANDO, PAUSADO, SATURADO.
REQ-017 PARADO --iniciar--> RODANDO; RODANDO --iniciar--> PAUSADO; PAUSADO --iniciar--> RODANDO.
REQ-018 Zerar pulse in any state SHALL load count 0 and go to PARADO on the next edge.
REQ-019 Zerar and iniciar pulses in the same cycle: zerar wins; next state PARADO.
REQ-020 Each tick in RODANDO SHALL increment the count by 1; a tick with count 9998 SHALL load 9999 and enter SATURADO.
REQ-021 SATURADO SHALL hold count 9999, stop the prescaler, ignore iniciar; only zerar (or reset) exits.
REQ-022 The count SHALL never exceed 9999 nor wrap to 0 except via zerar/reset.
REQ-023 dado_binario_saida SHALL be registered and SHALL reflect a new count 1 clk after the tick cycle.
REQ-024 rodando and estouro SHALL be registered decodes of the current state.

Reset
REQ-025 reset_n low SHALL immediately force state PARADO, count 0, prescaler 0, debouncer levels 0, pulses 0.
REQ-026 Reset values: dado_binario_saida=0, rodando=0, estouro=0; reset asserted mid-run SHALL discard all progress.
REQ-027 After reset release, a button already held high SHALL generate one pulse once debounced.

Configuration
REQ-028 Macro CRONOMETRO_VOLTA_EN defined: btn_volta exists; volta pulse in RODANDO freezes dado_binario_saida at the current count while counting continues internally; next volta pulse, PAUSADO, SATURADO entry or zerar releases it to the live count.
REQ-029 Volta pulse outside RODANDO SHALL be ignored; zerar SHALL clear the freeze.
REQ-030 Macro undefined: no btn_volta port, no freeze logic; dado_binario_saida always equals the live count.

Verification (CLK_HZ=100, TICK_HZ=10, DEBOUNCE_CYCLES=4)
REQ-031 Reset, press iniciar 10 cycles -> rodando=1; after 50 further clk, dado_binario_saida=5 (+/-1 for debounce alignment).
REQ-032 Bounce iniciar 1-0-1 at 2-cycle intervals, then hold -> exactly one state change.
REQ-033 Run to count 3, press iniciar (pause) mid-interval for 100 clk, press again -> count 3 throughout pause, fourth increment arrives after remaining fraction, not full 10 clk.
REQ-034 Force run to 9999 -> estouro=1, count stays 9999 for 200 clk, iniciar ignored; zerar -> count 0, estouro=0, state PARADO.
REQ-035 Debounced iniciar and zerar pulses in same cycle while PAUSADO -> PARADO, count 0, rodando=0.
REQ-036 With CRONOMETRO_VOLTA_EN: at count 7 press volta, wait 30 clk -> output 7; press volta -> output 10.
